// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of NUM_INPUTS valid/ready streams into one registered output stream.
// A winner keeps the grant for up to BURST_MAX beats; each output beat carries its source index.
module axis_rr_arbiter #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned IDX_WIDTH  = 2
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] idata,
  input  logic [NUM_INPUTS-1:0]            ivalid,
  output logic [NUM_INPUTS-1:0]            iready,
  output logic [DATA_WIDTH-1:0]            odata,
  output logic [IDX_WIDTH-1:0]             osrc,
  output logic                             ovalid,
  input  logic                             oready
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]            r_state;
  logic [IDX_WIDTH-1:0]  r_last;
  logic [IDX_WIDTH-1:0]  r_grant;
  logic [CNT_W-1:0]      r_count;

  logic [0:0]            w_state_nxt;
  logic [IDX_WIDTH-1:0]  w_last_nxt;
  logic [IDX_WIDTH-1:0]  w_grant_nxt;
  logic [CNT_W-1:0]      w_count_nxt;

  logic                  w_load;
  logic                  w_found;
  logic [IDX_WIDTH-1:0]  w_search;
  logic [IDX_WIDTH-1:0]  w_cur;
  logic                  w_cur_ok;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_cur_data;

  // Output register may take a new beat when empty or being drained this cycle.
  assign w_load = resetn && (!ovalid || oready);

  // Rotating priority search starting just after the last released grant.
  always_comb begin
    w_found  = 1'b0;
    w_search = '0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      if (ivalid[IDX_WIDTH'((int'(r_last) + k) % int'(NUM_INPUTS))]) begin
        w_found  = 1'b1;
        w_search = IDX_WIDTH'((int'(r_last) + k) % int'(NUM_INPUTS));
      end
    end
  end

  assign w_cur    = (r_state == S_BURST) ? r_grant : w_search;
  assign w_cur_ok = (r_state == S_BURST) ? 1'b1 : w_found;
  assign w_xfer   = w_load && w_cur_ok && ivalid[w_cur];

  always_comb begin
    iready     = '0;
    w_cur_data = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      if (w_cur == IDX_WIDTH'(i)) begin
        iready[i]  = w_load && w_cur_ok;
        w_cur_data = idata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output beat register; holds while downstream stalls.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovalid <= 1'b0;
      odata  <= '0;
      osrc   <= '0;
    end else if (w_load) begin
      ovalid <= w_xfer;
      if (w_xfer) begin
        odata <= w_cur_data;
        osrc  <= w_cur;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_last  <= IDX_WIDTH'(NUM_INPUTS - 1);
      r_grant <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Grant tracking: a burst ends on BURST_MAX beats or when the holder goes idle.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (BURST_MAX == 1) begin
            w_last_nxt = w_cur;
          end else begin
            w_grant_nxt = w_cur;
            w_count_nxt = CNT_W'(1);
            w_state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (w_load) begin
          if (w_xfer && (r_count + CNT_W'(1) != CNT_W'(BURST_MAX))) begin
            w_count_nxt = r_count + CNT_W'(1);
          end else begin
            w_last_nxt  = r_grant;
            w_count_nxt = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios plus a long random run, all checked
// against a transaction-level arbitration model and a per-source scoreboard.
module tb_axis_rr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BM    = 4;
  localparam int IW    = 2;
  localparam int BOUND = (N - 1) * BM;

  typedef struct {
    int src;
    int data;
  } beat_t;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic [N*DW-1:0] idata;
  logic [N-1:0]    ivalid = '0;
  logic            oready = 1'b0;
  logic [N-1:0]    iready, iready1;
  logic [DW-1:0]   odata, odata1;
  logic [IW-1:0]   osrc, osrc1;
  logic            ovalid, ovalid1;

  logic [DW-1:0]   src_data [N];
  logic [N-1:0]    acc_mask = '0;

  int total = 0;
  int bad   = 0;

  // model state
  int              m_owner, m_beats, m_last, m_os;
  bit              m_ov;
  logic [DW-1:0]   m_od;

  beat_t           log0[$];
  beat_t           log1[$];
  logic [DW-1:0]   sq [N][$];
  int              wt [N];
  int              max_wait = 0;

  axis_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .BURST_MAX(BM), .IDX_WIDTH(IW)) dut (
    .clock(clock), .resetn(resetn), .idata(idata), .ivalid(ivalid), .iready(iready),
    .odata(odata), .osrc(osrc), .ovalid(ovalid), .oready(oready)
  );

  axis_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .BURST_MAX(1), .IDX_WIDTH(IW)) dut1 (
    .clock(clock), .resetn(resetn), .idata(idata), .ivalid(ivalid), .iready(iready1),
    .odata(odata1), .osrc(osrc1), .ovalid(ovalid1), .oready(oready)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) idata[i*DW +: DW] = src_data[i];
  end

  // sources advance to their next beat after a handshake
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) if (acc_mask[i]) src_data[i] <= src_data[i] + 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // compare + model advance, once per cycle on the falling edge
  always @(negedge clock) begin : checker_p
    int           cur;
    bit           load, xfer, any_acc;
    logic [N-1:0] exp_ir;
    if (!resetn) begin
      chk("rst_iready", 32'(iready), 0);
      chk("rst_ovalid", 32'(ovalid), 0);
      m_owner = -1; m_beats = 0; m_last = N - 1;
      m_ov = 0; m_od = '0; m_os = 0;
      for (int i = 0; i < N; i++) begin
        sq[i].delete();
        wt[i] = 0;
      end
      acc_mask = '0;
    end else begin
      load = !m_ov || oready;
      cur  = -1;
      if (m_owner >= 0) cur = m_owner;
      else
        for (int k = 1; k <= N; k++)
          if (cur < 0 && ivalid[(m_last + k) % N]) cur = (m_last + k) % N;
      exp_ir = '0;
      if (load && cur >= 0) exp_ir[cur] = 1'b1;

      chk("iready", 32'(iready), 32'(exp_ir));
      chk("ovalid", 32'(ovalid), 32'(m_ov));
      chk("osrc",   32'(osrc),   32'(m_os));
      chk("odata",  32'(odata),  32'(m_od));

      // scoreboard: per-source order and no loss/duplication
      if (ovalid && oready) begin
        log0.push_back('{int'(osrc), int'(odata)});
        if (sq[osrc].size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_order", 32'(odata), 32'(sq[osrc].pop_front()));
      end
      if (ovalid1 && oready) log1.push_back('{int'(osrc1), int'(odata1)});
      any_acc = |(ivalid & iready);
      for (int i = 0; i < N; i++) begin
        if (ivalid[i] && iready[i]) begin
          sq[i].push_back(src_data[i]);
          wt[i] = 0;
        end else if (ivalid[i]) begin
          wt[i] += int'(any_acc);
          if (wt[i] > max_wait) max_wait = wt[i];
        end else begin
          wt[i] = 0;
        end
      end
      acc_mask = ivalid & iready;

      xfer = load && cur >= 0 && ivalid[cur];
      if (load) begin
        m_ov = xfer;
        if (xfer) begin
          m_od = src_data[cur];
          m_os = cur;
        end
      end
      if (m_owner < 0) begin
        if (xfer) begin
          if (BM == 1) m_last = cur;
          else begin
            m_owner = cur;
            m_beats = 1;
          end
        end
      end else if (load) begin
        if (xfer) begin
          m_beats++;
          if (m_beats == BM) begin
            m_last  = m_owner;
            m_owner = -1;
          end
        end else begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  end

  task automatic step(input logic [N-1:0] v, input logic r);
    @(posedge clock);
    #1;
    ivalid = v;
    oready = r;
  endtask

  task automatic rst_pulse();
    @(posedge clock);
    #1;
    resetn = 1'b0;
    ivalid = '0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic check_conservation(input string name);
    for (int i = 0; i < N; i++)
      chk(name, 32'(sq[i].size()), 32'((ovalid && int'(osrc) == i) ? 1 : 0));
  endtask

  initial begin : main_p
    int exp1 [9];
    int exp2 [6];
    logic [DW-1:0] hold_d;
    logic [IW-1:0] hold_s;
    logic [N-1:0]  v;
    exp1 = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    exp2 = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) src_data[i] = 8'(i * 16);

    // all sources valid from reset release
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    ivalid = 4'hF;
    oready = 1'b1;
    log0.delete();
    log1.delete();
    repeat (11) step(4'hF, 1'b1);
    chk("t1_len", 32'(log0.size() >= 9), 1);
    if (log0.size() >= 9) begin
      for (int k = 0; k < 9; k++) chk("t1_osrc", 32'(log0[k].src), 32'(exp1[k]));
      chk("t1_data0", 32'(log0[0].data), 32'h00);
      chk("t1_data3", 32'(log0[3].data), 32'h03);
      chk("t1_data4", 32'(log0[4].data), 32'h10);
    end
    chk("t2_len", 32'(log1.size() >= 6), 1);
    if (log1.size() >= 6)
      for (int k = 0; k < 6; k++) chk("t2_osrc", 32'(log1[k].src), 32'(exp2[k]));

    // lone source drops valid mid-burst; next source served right after release
    rst_pulse();
    src_data[2] = 8'hA0;
    src_data[1] = 8'h10;
    log0.delete();
    ivalid = 4'b0100;
    step(4'b0100, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("t3_len", 32'(log0.size()), 3);
    if (log0.size() == 3) begin
      chk("t3_d0", 32'(log0[0].data), 32'hA0);
      chk("t3_d1", 32'(log0[1].data), 32'hA1);
      chk("t3_d2", 32'(log0[2].data), 32'h10);
      chk("t3_s2", 32'(log0[2].src), 1);
    end

    // output stall holds the register and blocks all inputs
    rst_pulse();
    repeat (3) step(4'hF, 1'b1);
    step(4'hF, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c == 0) begin
        hold_d = odata;
        hold_s = osrc;
        chk("t4_ovalid", 32'(ovalid), 1);
      end else begin
        chk("t4_odata", 32'(odata), 32'(hold_d));
        chk("t4_osrc", 32'(osrc), 32'(hold_s));
      end
      chk("t4_iready", 32'(iready), 0);
      @(posedge clock);
      #1;
    end
    repeat (6) step(4'hF, 1'b1);
    repeat (3) step(4'h0, 1'b1);
    check_conservation("t4_cons");

    // reset in the middle of a burst from input 3
    rst_pulse();
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    @(posedge clock);
    #1;
    chk("t5_pre_ovalid", 32'(ovalid), 1);
    chk("t5_pre_osrc", 32'(osrc), 3);
    resetn = 1'b0;
    ivalid = 4'hF;
    #1;
    chk("t5_async_ovalid", 32'(ovalid), 0);
    chk("t5_async_osrc", 32'(osrc), 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    log0.delete();
    repeat (3) step(4'hF, 1'b1);
    chk("t5_len", 32'(log0.size() >= 1), 1);
    if (log0.size() >= 1) chk("t5_first", 32'(log0[0].src), 0);

    // random traffic and backpressure
    rst_pulse();
    log0.delete();
    max_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 3) != 0);
      step(v, 1'($urandom_range(0, 3) != 0));
    end
    repeat (4) step(4'h0, 1'b1);
    check_conservation("t6_cons");
    chk("t6_starve", 32'(max_wait <= BOUND), 1);
    chk("t6_activity", 32'(log0.size() > 1000), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
